// File: rtl/vga_pkg.sv
// vga_pkg: definitions shared by the region scheduler slice.
//   CW / SELW      : coordinate width and tile-select width
//   FLD_*          : cfg_field encodings for the config port
//   region_t       : one programmable rectangle (x0, x1, y0, y1, tile, enable, blink)
//   cfg_state_e    : config/commit FSM states
//   region_covers  : inclusive unsigned rectangle test against a pixel
package vga_pkg;

    localparam int CW   = 10;
    localparam int SELW = 4;

    localparam logic [2:0] FLD_X0     = 3'd0;
    localparam logic [2:0] FLD_X1     = 3'd1;
    localparam logic [2:0] FLD_Y0     = 3'd2;
    localparam logic [2:0] FLD_Y1     = 3'd3;
    localparam logic [2:0] FLD_TILE   = 3'd4;
    localparam logic [2:0] FLD_ENABLE = 3'd5;
    localparam logic [2:0] FLD_BLINK  = 3'd6;
    localparam logic [2:0] FLD_RSVD   = 3'd7;

    typedef struct packed {
        logic [CW-1:0]   x0;
        logic [CW-1:0]   x1;
        logic [CW-1:0]   y0;
        logic [CW-1:0]   y1;
        logic [SELW-1:0] tile;
        logic            enable;
        logic            blink;
    } region_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } cfg_state_e;

    // An inverted rectangle (x0 > x1 or y0 > y1) can never satisfy both
    // inequalities, so it never hits without any special casing.
    function automatic logic region_covers(region_t r, logic [CW-1:0] h, logic [CW-1:0] v);
        return r.enable && (r.x0 <= h) && (h <= r.x1) && (r.y0 <= v) && (v <= r.y1);
    endfunction

endpackage

// File: rtl/region_prio_enc.sv
// region_prio_enc: combinational priority encoder for the region scheduler.
// The lowest-index hitting region supplies its tile; with no hit or with
// bright low the background tile is selected.
// Ports:
//   hit      in  NUM_REGIONS       per-region hit vector
//   tiles    in  NUM_REGIONS*SELW  tile of region i at [i*SELW +: SELW]
//   bright   in  1                 active-video flag aligned with hit
//   tselect  out SELW              selected tile
module region_prio_enc #(
    parameter int              NUM_REGIONS = 4,
    parameter int              SELW        = vga_pkg::SELW,
    parameter logic [SELW-1:0] BG_TILE     = '0
) (
    input  logic [NUM_REGIONS-1:0]      hit,
    input  logic [NUM_REGIONS*SELW-1:0] tiles,
    input  logic                        bright,
    output logic [SELW-1:0]             tselect
);

    // Scan from the highest index down so the lowest hitting index wins.
    always_comb begin
        tselect = BG_TILE;
        if (bright) begin
            for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
                if (hit[i]) begin
                    tselect = tiles[i*SELW +: SELW];
                end
            end
        end
    end

endmodule

// File: rtl/region_scheduler.sv
// region_scheduler: selects the ColorSelector tile source from NUM_REGIONS
// programmable rectangles. Region writes land in shadow registers and are
// copied to the live set in one cycle at the start of vertical blank, so a
// frame is never drawn with a half-updated map.
// Optional feature: define REGION_BLINK_EN to store a per-region blink bit
// (cfg_field 6); blinking regions are suppressed while frame_cnt[5] is set.
// Ports:
//   clk, rst            pixel clock, asynchronous active-low reset
//   hcount, vcount      raster position from VController
//   bright              active-video flag
//   cfg_valid/cfg_ready config write handshake
//   cfg_idx/field/data  target region, field select, write data
//   cfg_commit          request to commit shadow to live at the next frame point
//   tselect, tsel_valid selected tile and delayed bright (2-cycle latency)
//   region_hit          raw per-region hit vector aligned with tselect
//   commit_done         one-cycle pulse in the cycle after the live set updates
//   frame_cnt           frames since reset, wraps 255 -> 0
module region_scheduler
    import vga_pkg::*;
#(
    parameter int              NUM_REGIONS = 4,
    parameter int              CW          = vga_pkg::CW,
    parameter int              SELW        = vga_pkg::SELW,
    parameter int              V_ACTIVE    = 480,
    parameter logic [SELW-1:0] BG_TILE     = '0,
    localparam int             IW          = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CW-1:0]          hcount,
    input  logic [CW-1:0]          vcount,
    input  logic                   bright,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [IW-1:0]          cfg_idx,
    input  logic [2:0]             cfg_field,
    input  logic [CW-1:0]          cfg_data,
    input  logic                   cfg_commit,
    output logic [SELW-1:0]        tselect,
    output logic                   tsel_valid,
    output logic [NUM_REGIONS-1:0] region_hit,
    output logic                   commit_done,
    output logic [7:0]             frame_cnt
);

    cfg_state_e                 state_reg;
    logic                       cfg_ready_reg;
    logic                       commit_done_reg;
    logic [7:0]                 frame_cnt_reg;

    logic                       frame_point;
    logic                       cfg_fire;
    logic                       commit_now;
    logic                       blink_phase;

    logic [NUM_REGIONS-1:0]      hit_now;
    logic [NUM_REGIONS*SELW-1:0] tiles_flat;

    logic [NUM_REGIONS-1:0]      hit_s1_reg;
    logic                        bright_s1_reg;
    logic [NUM_REGIONS-1:0]      region_hit_reg;
    logic [SELW-1:0]             tselect_reg;
    logic                        tsel_valid_reg;
    logic [SELW-1:0]             tselect_next;

    assign frame_point = (hcount == '0) && (vcount == CW'(V_ACTIVE));
    assign cfg_fire    = cfg_valid && cfg_ready_reg;
    // The live copy happens on the edge that leaves PENDING, so the COMMIT
    // cycle already sees the new map and flags it with commit_done.
    assign commit_now  = (state_reg == PENDING) && frame_point;

`ifdef REGION_BLINK_EN
    assign blink_phase = frame_cnt_reg[5];
`else
    // Blink bits are never written in this build, so they stay 0 and the
    // suppression term below is inert.
    assign blink_phase = 1'b0;
`endif

    // Per-region shadow/live storage and the S1 hit term.
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        region_t shadow_reg;
        region_t live_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                shadow_reg <= '0;
                live_reg   <= '0;
            end else begin
                // cfg_ready is low outside IDLE, which freezes the shadow set
                // while a commit is outstanding.
                if (cfg_fire && (cfg_idx == IW'(gi))) begin
                    case (cfg_field)
                        FLD_X0:     shadow_reg.x0     <= cfg_data;
                        FLD_X1:     shadow_reg.x1     <= cfg_data;
                        FLD_Y0:     shadow_reg.y0     <= cfg_data;
                        FLD_Y1:     shadow_reg.y1     <= cfg_data;
                        FLD_TILE:   shadow_reg.tile   <= cfg_data[SELW-1:0];
                        FLD_ENABLE: shadow_reg.enable <= cfg_data[0];
`ifdef REGION_BLINK_EN
                        FLD_BLINK:  shadow_reg.blink  <= cfg_data[0];
`endif
                        default:    ;
                    endcase
                end
                if (commit_now) begin
                    live_reg <= shadow_reg;
                end
            end
        end

        assign hit_now[gi] = region_covers(live_reg, hcount, vcount)
                             && !(live_reg.blink && blink_phase);
        assign tiles_flat[gi*SELW +: SELW] = live_reg.tile;
    end

    // Config/commit FSM with registered handshake outputs; frame_cnt runs
    // independently of the FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            cfg_ready_reg   <= 1'b1;
            commit_done_reg <= 1'b0;
            frame_cnt_reg   <= 8'd0;
        end else begin
            commit_done_reg <= 1'b0;
            if (frame_point) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
            case (state_reg)
                IDLE: begin
                    // A write in this same cycle still lands (cfg_ready is
                    // high), so it is part of the commit.
                    if (cfg_commit) begin
                        state_reg     <= PENDING;
                        cfg_ready_reg <= 1'b0;
                    end
                end
                PENDING: begin
                    if (frame_point) begin
                        state_reg       <= COMMIT;
                        commit_done_reg <= 1'b1;
                    end
                end
                COMMIT: begin
                    state_reg     <= IDLE;
                    cfg_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    cfg_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // S2 tile selection. Live tiles only change during blanking, so reading
    // them here alongside the S1 hit vector never mixes maps in active video.
    region_prio_enc #(
        .NUM_REGIONS (NUM_REGIONS),
        .SELW        (SELW),
        .BG_TILE     (BG_TILE)
    ) u_prio_enc (
        .hit     (hit_s1_reg),
        .tiles   (tiles_flat),
        .bright  (bright_s1_reg),
        .tselect (tselect_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_s1_reg     <= '0;
            bright_s1_reg  <= 1'b0;
            region_hit_reg <= '0;
            tselect_reg    <= BG_TILE;
            tsel_valid_reg <= 1'b0;
        end else begin
            hit_s1_reg     <= hit_now;
            bright_s1_reg  <= bright;
            region_hit_reg <= hit_s1_reg;
            tselect_reg    <= tselect_next;
            tsel_valid_reg <= bright_s1_reg;
        end
    end

    assign cfg_ready   = cfg_ready_reg;
    assign commit_done = commit_done_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign tselect     = tselect_reg;
    assign tsel_valid  = tsel_valid_reg;
    assign region_hit  = region_hit_reg;

endmodule
